// File: rtl/alu_issue_ctrl_if.sv
// Instruction handshake between the decoder (master) and the ALU issue controller (slave).
// Fields are sampled only while the controller signals ready.
interface alu_issue_ctrl_if #(
    parameter int NumOpCodeBits = 5,
    parameter int ParamBits     = 8,
    parameter int AddrBits      = 2
);
    logic                     instr_valid;
    logic                     instr_ready;
    logic [NumOpCodeBits-1:0] instr_opcode;
    logic [AddrBits-1:0]      instr_rd;
    logic [AddrBits-1:0]      instr_rs;
    logic [ParamBits-1:0]     instr_param;

    modport master (
        output instr_valid,
        output instr_opcode,
        output instr_rd,
        output instr_rs,
        output instr_param,
        input  instr_ready
    );

    modport slave (
        input  instr_valid,
        input  instr_opcode,
        input  instr_rd,
        input  instr_rs,
        input  instr_param,
        output instr_ready
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue/write-back controller for ALU_J: IDLE -> EXEC -> WB, 4-entry regfile, status flags.
// Optional ALU_ISSUE_DBG_PORT_EN adds a combinational register-file read port.
module alu_issue_ctrl #(
    parameter int DataWidth     = 8,
    parameter int NumOpCodeBits = 5,
    parameter int ParamBits     = 8,
    parameter int NumStatusBits = 3,
    parameter int NumRegs       = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    alu_issue_ctrl_if.slave          instr,
    output logic [NumOpCodeBits-1:0] alu_opcode,
    output logic [DataWidth-1:0]     alu_operand1,
    output logic [DataWidth-1:0]     alu_operand2,
    output logic [ParamBits-1:0]     alu_param,
    input  logic [DataWidth-1:0]     alu_result,
    input  logic [NumStatusBits-1:0] alu_status,
    output logic                     wb_valid,
    output logic                     wb_we,
    output logic [$clog2(NumRegs)-1:0] wb_addr,
    output logic [DataWidth-1:0]     wb_data,
    output logic [NumStatusBits-1:0] status,
    output logic                     illegal_op
`ifdef ALU_ISSUE_DBG_PORT_EN
    ,
    input  logic [$clog2(NumRegs)-1:0] dbg_addr,
    output logic [DataWidth-1:0]     dbg_data
`endif
);
    localparam int AW = $clog2(NumRegs);
    localparam logic [NumOpCodeBits-1:0] OpNop = '0;
    localparam logic [NumOpCodeBits-1:0] OpVal = NumOpCodeBits'(8);

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    state_t state, state_nxt;

    logic [NumOpCodeBits-1:0] op_q;
    logic [AW-1:0]            rd_q;
    logic [AW-1:0]            rs_q;
    logic [ParamBits-1:0]     param_q;
    logic [DataWidth-1:0]     res_q;
    logic [NumStatusBits-1:0] st_q;
    logic [DataWidth-1:0]     rf [NumRegs];

    logic accept;
    logic legal_q;

    assign accept  = instr.instr_valid && (state == IDLE);
    assign legal_q = (op_q != OpNop) && (op_q <= OpVal);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (instr.instr_valid) state_nxt = EXEC;
            EXEC: state_nxt = WB;
            WB:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        instr.instr_ready = 1'b0;
        alu_opcode   = OpNop;
        alu_operand1 = '0;
        alu_operand2 = '0;
        alu_param    = '0;
        wb_valid     = 1'b0;
        wb_we        = 1'b0;
        wb_addr      = '0;
        wb_data      = '0;
        unique case (state)
            IDLE: instr.instr_ready = 1'b1;
            EXEC: begin
                alu_opcode   = op_q;
                alu_operand1 = rf[rd_q];
                alu_operand2 = rf[rs_q];
                alu_param    = param_q;
            end
            WB: begin
                wb_valid = 1'b1;
                wb_we    = legal_q;
                wb_addr  = rd_q;
                wb_data  = res_q;
            end
            default: ;
        endcase
    end

    // Datapath: latch on accept, capture ALU in EXEC, commit in WB.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q       <= OpNop;
            rd_q       <= '0;
            rs_q       <= '0;
            param_q    <= '0;
            res_q      <= '0;
            st_q       <= '0;
            status     <= '0;
            illegal_op <= 1'b0;
            for (int i = 0; i < NumRegs; i++) rf[i] <= '0;
        end else begin
            if (accept) begin
                op_q    <= instr.instr_opcode;
                rd_q    <= instr.instr_rd;
                rs_q    <= instr.instr_rs;
                param_q <= instr.instr_param;
                if (instr.instr_opcode > OpVal) illegal_op <= 1'b1;
            end
            if (state == EXEC) begin
                res_q <= alu_result;
                st_q  <= alu_status;
            end
            if (state == WB && legal_q) begin
                rf[rd_q] <= res_q;
                status   <= st_q;
            end
        end
    end

`ifdef ALU_ISSUE_DBG_PORT_EN
    assign dbg_data = rf[dbg_addr];
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl with a behavioural ALU_J stand-in and a write-back scoreboard.
// ALU status model: bit0 carry/borrow, bit1 zero, bit2 sign.
module tb_alu_issue_ctrl;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [4:0] alu_opcode;
    logic [7:0] alu_operand1;
    logic [7:0] alu_operand2;
    logic [7:0] alu_param;
    logic [7:0] alu_result;
    logic [2:0] alu_status;
    logic       wb_valid;
    logic       wb_we;
    logic [1:0] wb_addr;
    logic [7:0] wb_data;
    logic [2:0] status;
    logic       illegal_op;
`ifdef ALU_ISSUE_DBG_PORT_EN
    logic [1:0] dbg_addr = 2'd0;
    logic [7:0] dbg_data;
`endif

    alu_issue_ctrl_if ifc ();

    alu_issue_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .instr        (ifc),
        .alu_opcode   (alu_opcode),
        .alu_operand1 (alu_operand1),
        .alu_operand2 (alu_operand2),
        .alu_param    (alu_param),
        .alu_result   (alu_result),
        .alu_status   (alu_status),
        .wb_valid     (wb_valid),
        .wb_we        (wb_we),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .status       (status),
        .illegal_op   (illegal_op)
`ifdef ALU_ISSUE_DBG_PORT_EN
        ,
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data)
`endif
    );

    always #5 clk = ~clk;

    // ALU_J stand-in
    logic [8:0] alu_t;
    always_comb begin
        alu_t = '0;
        case (alu_opcode)
            5'd1: alu_t = {1'b0, alu_operand1} + {1'b0, alu_operand2};
            5'd2: alu_t = {1'b0, alu_operand1} - {1'b0, alu_operand2};
            5'd3: alu_t = {1'b0, alu_operand1 & alu_operand2};
            5'd4: alu_t = {1'b0, alu_operand1 | alu_operand2};
            5'd5: alu_t = {1'b0, ~alu_operand1};
            5'd6: alu_t = {alu_operand1, 1'b0};
            5'd7: alu_t = {alu_operand1[0], 1'b0, alu_operand1[7:1]};
            5'd8: alu_t = {1'b0, alu_param};
            default: alu_t = '0;
        endcase
        alu_result = alu_t[7:0];
        alu_status = {alu_t[7], alu_t[7:0] == 8'd0, alu_t[8]};
    end

    typedef struct {
        logic       we;
        logic [1:0] addr;
        logic [7:0] data;
        logic [2:0] st;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   last_acc = -100;
    int   acc_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pop on each write-back, check status the cycle after.
    logic       st_pend = 1'b0;
    logic [2:0] st_exp = '0;
    always @(negedge clk) begin
        exp_t e;
        if (st_pend) begin
            checks++;
            if (status !== st_exp) begin
                failures++;
                $display("FAIL status got=%b exp=%b", status, st_exp);
            end
            st_pend = 1'b0;
        end
        if (wb_valid === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL wb_unexpected got=1 exp=0");
            end else begin
                e = q.pop_front();
                if (wb_we !== e.we) begin
                    failures++;
                    $display("FAIL wb_we got=%b exp=%b", wb_we, e.we);
                end
                if (e.we) begin
                    checks++;
                    if (wb_addr !== e.addr || wb_data !== e.data) begin
                        failures++;
                        $display("FAIL wb_addr_data got=%0d/%h exp=%0d/%h",
                                 wb_addr, wb_data, e.addr, e.data);
                    end
                end
                st_pend = 1'b1;
                st_exp  = e.st;
            end
        end
    end

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic send(input logic [4:0] op, input logic [1:0] rd, input logic [1:0] rs,
                        input logic [7:0] prm);
        int n = 0;
        @(negedge clk);
        while (ifc.instr_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            failures++;
            $display("FAIL ready_timeout got=0 exp=1");
        end
        ifc.instr_valid  = 1'b1;
        ifc.instr_opcode = op;
        ifc.instr_rd     = rd;
        ifc.instr_rs     = rs;
        ifc.instr_param  = prm;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        ifc.instr_valid  = 1'b0;
        ifc.instr_opcode = 5'h1f;
        ifc.instr_param  = 8'h5a;
    endtask

    task automatic issue(input logic [4:0] op, input logic [1:0] rd, input logic [1:0] rs,
                         input logic [7:0] prm, input logic we, input logic [7:0] d,
                         input logic [2:0] st);
        exp_t e;
        e.we = we; e.addr = rd; e.data = d; e.st = st;
        q.push_back(e);
        send(op, rd, rs, prm);
        last_acc = acc_cyc;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || ifc.instr_ready !== 1'b1 || st_pend) && n < 30) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d exp=0", q.size());
        end
    endtask

    initial begin
        int prev;
        ifc.instr_valid  = 1'b0;
        ifc.instr_opcode = '0;
        ifc.instr_rd     = '0;
        ifc.instr_rs     = '0;
        ifc.instr_param  = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {7'd0, ifc.instr_ready}, 8'd1);
        chk("rst_wb_valid", {7'd0, wb_valid}, 8'd0);
        chk("rst_status", {5'd0, status}, 8'd0);
        chk("rst_alu_op", {3'd0, alu_opcode}, 8'd0);
        reset_n = 1'b1;

        issue(5'd8, 2'd0, 2'd0, 8'd1, 1'b1, 8'd1, 3'b000);
        issue(5'd8, 2'd1, 2'd0, 8'd3, 1'b1, 8'd3, 3'b000);
        issue(5'd1, 2'd0, 2'd1, 8'd0, 1'b1, 8'd4, 3'b000);
        issue(5'd8, 2'd2, 2'd0, 8'd255, 1'b1, 8'd255, 3'b100);
        issue(5'd8, 2'd3, 2'd0, 8'd2, 1'b1, 8'd2, 3'b000);
        prev = last_acc;
        issue(5'd1, 2'd2, 2'd3, 8'd0, 1'b1, 8'd1, 3'b001);
        chk("accept_spacing", 8'(last_acc - prev), 8'd3);

        issue(5'd8, 2'd0, 2'd0, 8'hcc, 1'b1, 8'hcc, 3'b100);
        issue(5'd8, 2'd1, 2'd0, 8'haa, 1'b1, 8'haa, 3'b100);
        issue(5'd3, 2'd0, 2'd1, 8'd0, 1'b1, 8'h88, 3'b100);
        issue(5'd5, 2'd0, 2'd0, 8'd0, 1'b1, 8'h77, 3'b000);
        drain();
        chk("illegal_before", {7'd0, illegal_op}, 8'd0);

        issue(5'b1_0000, 2'd0, 2'd1, 8'd9, 1'b0, 8'd0, 3'b000);
        drain();
        chk("illegal_set", {7'd0, illegal_op}, 8'd1);
        issue(5'd0, 2'd0, 2'd1, 8'd9, 1'b0, 8'd0, 3'b000);
        issue(5'd4, 2'd0, 2'd1, 8'd0, 1'b1, 8'hff, 3'b100);
        issue(5'd2, 2'd3, 2'd1, 8'd0, 1'b1, 8'h58, 3'b001);
        issue(5'd6, 2'd1, 2'd1, 8'd0, 1'b1, 8'h54, 3'b001);
        issue(5'd7, 2'd1, 2'd1, 8'd0, 1'b1, 8'h2a, 3'b000);
        issue(5'd1, 2'd2, 2'd2, 8'd0, 1'b1, 8'h02, 3'b000);
        drain();
        chk("illegal_sticky", {7'd0, illegal_op}, 8'd1);

        send(5'd1, 2'd0, 2'd1, 8'd0);
        @(negedge clk);
        chk("exec_alu_op", {3'd0, alu_opcode}, 8'd1);
        chk("exec_operand2", alu_operand2, 8'h2a);
        reset_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_wb", {7'd0, wb_valid}, 8'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {7'd0, ifc.instr_ready}, 8'd1);
        chk("post_rst_illegal", {7'd0, illegal_op}, 8'd0);
        chk("post_rst_status", {5'd0, status}, 8'd0);
`ifdef ALU_ISSUE_DBG_PORT_EN
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1;
            chk("dbg_reg", dbg_data, 8'd0);
        end
`endif
        issue(5'd4, 2'd0, 2'd1, 8'd0, 1'b1, 8'h00, 3'b010);
        issue(5'd4, 2'd2, 2'd3, 8'd0, 1'b1, 8'h00, 3'b010);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=1 exp=0");
        $fatal(1);
    end
endmodule
